// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and serve-direction constants for the Pong controller
package pong_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic DIR_TOP = 1'b0;
  localparam logic DIR_BOT = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 3-flop synchronizer plus rising-edge detector for an asynchronous button
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 3'b000;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], din_i};
      prev_q <= sync_q[2];
    end
  end

  assign pulse_o = sync_q[2] & ~prev_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong game sequencer: serve/play/point/over, scoring, motion gating.
// AUTO_SERVE_EN selects a timed serve; otherwise a start press after the serve wait launches the ball.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               start,
  input  logic               miss_top,
  input  logic               miss_bot,
  output logic               move_en,
  output logic               ball_rst,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_top,
  output logic [SCORE_W-1:0] score_bot,
  output logic               game_over,
  output logic               winner,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic [SCORE_W-1:0] top_q, top_d, bot_q, bot_d;
  logic               dir_q, dir_d, win_q, win_d;
  logic               move_en_q, ball_rst_q, game_over_q;
  logic               start_evt;

  sync_edge u_start_sync (
    .clk_i   (pixel_clk),
    .rst_i   (rst),
    .din_i   (start),
    .pulse_o (start_evt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    top_d   = top_q;
    bot_d   = bot_q;
    dir_d   = dir_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_evt) begin
          top_d   = '0;
          bot_d   = '0;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
`ifdef AUTO_SERVE_EN
        if (fsync) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`else
        // rdy_q marks the serve wait as complete; only then may start launch the ball
        if (rdy_q) begin
          if (start_evt) begin
            rdy_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_PLAY;
          end
        end else if (fsync) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d = '0;
            rdy_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`endif
      end
      ST_PLAY: begin
        if (miss_top && miss_bot) begin
          state_d = ST_POINT;
        end else if (miss_top) begin
          bot_d   = bot_q + SCORE_W'(1);
          dir_d   = DIR_TOP;
          state_d = ST_POINT;
        end else if (miss_bot) begin
          top_d   = top_q + SCORE_W'(1);
          dir_d   = DIR_BOT;
          state_d = ST_POINT;
        end
      end
      ST_POINT: begin
        if (fsync) begin
          if (cnt_q == POINT_LAST) begin
            cnt_d = '0;
            if (top_q == WIN || bot_q == WIN) begin
              win_d   = (bot_q == WIN);
              state_d = ST_OVER;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      top_q       <= '0;
      bot_q       <= '0;
      dir_q       <= DIR_TOP;
      win_q       <= 1'b0;
      move_en_q   <= 1'b0;
      ball_rst_q  <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      top_q       <= top_d;
      bot_q       <= bot_d;
      dir_q       <= dir_d;
      win_q       <= win_d;
      move_en_q   <= (state_d == ST_PLAY);
      ball_rst_q  <= !(state_d == ST_PLAY || state_d == ST_POINT);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign move_en   = move_en_q;
  assign ball_rst  = ball_rst_q;
  assign serve_dir = dir_q;
  assign score_top = top_q;
  assign score_bot = bot_q;
  assign game_over = game_over_q;
  assign winner    = win_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - directed scoreboard bench for pong_game_ctrl (either AUTO_SERVE_EN setting)
module tb_pong_game_ctrl;

  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 90;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4;

  logic       pixel_clk = 1'b0;
  logic       rst, fsync, start, miss_top, miss_bot;
  logic       move_en, ball_rst, serve_dir, game_over, winner;
  logic [3:0] score_top, score_bot;
  logic [2:0] state;

  pong_game_ctrl dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .fsync     (fsync),
    .start     (start),
    .miss_top  (miss_top),
    .miss_bot  (miss_bot),
    .move_en   (move_en),
    .ball_rst  (ball_rst),
    .serve_dir (serve_dir),
    .score_top (score_top),
    .score_bot (score_bot),
    .game_over (game_over),
    .winner    (winner),
    .state     (state)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [2:0] st;
    logic [3:0] top;
    logic [3:0] bot;
    logic       dir;
    logic       win;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  logic [3:0] m_top, m_bot;
  logic       m_dir, m_win;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] s);
    exp_t e;
    e.st  = s;
    e.top = m_top;
    e.bot = m_bot;
    e.dir = m_dir;
    e.win = m_win;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp({t, ".state"}, state, e.st);
      cmp({t, ".score_top"}, score_top, e.top);
      cmp({t, ".score_bot"}, score_bot, e.bot);
      cmp({t, ".serve_dir"}, serve_dir, e.dir);
      cmp({t, ".move_en"}, move_en, (e.st == S_PLAY));
      cmp({t, ".ball_rst"}, ball_rst, !(e.st == S_PLAY || e.st == S_POINT));
      cmp({t, ".game_over"}, game_over, (e.st == S_OVER));
      if (e.st == S_OVER) cmp({t, ".winner"}, winner, e.win);
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      fsync = 1'b1;
      tick();
      fsync = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic go_play(input string tag);
`ifdef AUTO_SERVE_EN
    frames(SERVE_FRAMES - 1);
    cmp({tag, ".pre"}, state, S_SERVE);
    fsync = 1'b1;
    push_exp(tag, S_PLAY);
    tick();
    fsync = 1'b0;
    check_out();
    repeat (3) tick();
`else
    frames(10);
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    repeat (4) tick();
    cmp({tag, ".early_start"}, state, S_SERVE);
    frames(SERVE_FRAMES - 10);
    cmp({tag, ".pre"}, state, S_SERVE);
    start = 1'b1;
    push_exp(tag, S_PLAY);
    repeat (3) tick();
    cmp({tag, ".lat3"}, state, S_SERVE);
    tick();
    check_out();
    start = 1'b0;
    repeat (4) tick();
`endif
  endtask

  task automatic miss(input string tag, input logic t, input logic b, input logic with_fs);
    if (t && !b) begin
      m_bot = m_bot + 4'd1;
      m_dir = 1'b0;
    end else if (b && !t) begin
      m_top = m_top + 4'd1;
      m_dir = 1'b1;
    end
    miss_top = t;
    miss_bot = b;
    fsync    = with_fs;
    push_exp(tag, S_POINT);
    tick();
    miss_top = 1'b0;
    miss_bot = 1'b0;
    fsync    = 1'b0;
    check_out();
    repeat (3) tick();
  endtask

  task automatic point_wait(input string tag, input logic [2:0] nxt);
    frames(POINT_FRAMES - 1);
    cmp({tag, ".hold"}, state, S_POINT);
    if (nxt == S_OVER) m_win = (m_bot == 4'd7);
    fsync = 1'b1;
    push_exp(tag, nxt);
    tick();
    fsync = 1'b0;
    check_out();
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; fsync = 1'b0; start = 1'b0; miss_top = 1'b0; miss_bot = 1'b0;
    m_top = 4'd0; m_bot = 4'd0; m_dir = 1'b0; m_win = 1'b0;
    tick();
    push_exp("reset", S_IDLE);
    tick();
    check_out();
    rst = 1'b0;
    tick();

    start = 1'b1;
    push_exp("start", S_SERVE);
    repeat (3) tick();
    cmp("start_lat3", state, S_IDLE);
    tick();
    check_out();
    repeat (6) tick();
    start = 1'b0;
    repeat (4) tick();

    go_play("serve1");
    miss("miss_top_fs", 1'b1, 1'b0, 1'b1);

    miss_top = 1'b1;
    push_exp("miss_in_point", S_POINT);
    tick();
    miss_top = 1'b0;
    tick();
    check_out();
    point_wait("point1", S_SERVE);

    miss_top = 1'b1;
    push_exp("miss_in_serve", S_SERVE);
    tick();
    miss_top = 1'b0;
    tick();
    check_out();

    go_play("serve2");
    start = 1'b1;
    push_exp("start_in_play", S_PLAY);
    repeat (6) tick();
    start = 1'b0;
    repeat (4) tick();
    check_out();

    miss("both_miss", 1'b1, 1'b1, 1'b0);
    point_wait("point2", S_SERVE);

    for (int i = 1; i <= 7; i++) begin
      go_play($sformatf("rally%0d", i));
      miss($sformatf("rally%0d_miss", i), 1'b0, 1'b1, 1'b0);
      point_wait($sformatf("rally%0d_pt", i), (i == 7) ? S_OVER : S_SERVE);
    end

    m_top = 4'd0;
    m_bot = 4'd0;
    start = 1'b1;
    push_exp("restart", S_SERVE);
    repeat (3) tick();
    cmp("restart_lat3", state, S_OVER);
    tick();
    check_out();
    start = 1'b0;
    repeat (4) tick();

    go_play("g2_s1");
    miss("g2_m1", 1'b0, 1'b1, 1'b0);
    point_wait("g2_p1", S_SERVE);
    go_play("g2_s2");
    miss("g2_m2", 1'b1, 1'b0, 1'b1);
    point_wait("g2_p2", S_SERVE);
    go_play("g2_s3");
    miss("g2_m3", 1'b0, 1'b1, 1'b0);
    point_wait("g2_p3", S_SERVE);
    go_play("g2_s4");
    miss("g2_m4", 1'b1, 1'b0, 1'b0);
    point_wait("g2_p4", S_SERVE);
    go_play("g2_s5");
    miss("g2_m5", 1'b0, 1'b1, 1'b0);

    rst = 1'b1;
    m_top = 4'd0;
    m_bot = 4'd0;
    m_dir = 1'b0;
    push_exp("mid_reset", S_IDLE);
    tick();
    check_out();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-sequencing controller for the Pong display pipeline. It gates the per-frame motion updates of the paddles and ball, holds the ball at serve position between rallies, and keeps both players' scores. It also declares the winner. It sits between the HDMI timing generator (fsync) and the paddle/ball objects; the top level ANDs fsync with move_en before driving the objects' fsync inputs, and drives the ball's reset from ball_rst.

## Interface
- SERVE_FRAMES, 60: frames the ball is held before auto-serve.
- POINT_FRAMES, 90: frames the ball is frozen after a miss.
- WIN_SCORE, 7: score that ends the game; must be ≥1.
- SCORE_W, 4: score width; 2**SCORE_W > WIN_SCORE.
- pixel_clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  reset rst, synchronous, active-high; clock pixel_clk.
- fsync  in  1  one-cycle pulse per frame.
- start  in  1  raw button, asynchronous; synchronized internally.
- miss_top  in  1  one-cycle pulse: ball passed the top paddle.
- miss_bot  in  1  one-cycle pulse: ball passed the bottom paddle.
- move_en  out  1  objects may update this frame.
- ball_rst  out  1  hold ball at centre serve position.
- serve_dir  out  1  0 = serve toward top, 1 = toward bottom.
- score_top  out  SCORE_W  top player's score.
- score_bot  out  SCORE_W  bottom player's score.
- game_over  out  1  high in OVER.
- winner  out  1  0 = top won, 1 = bottom won; valid while game_over.
- state  out  3  current state encoding, for debug/overlay.

## Operation
- States: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Encodings 5–7 recover to IDLE on the next cycle.
- Reset values: state IDLE, scores 0, serve_dir 0, frame counter 0, move_en 0, ball_rst 1, game_over 0, winner 0.
- start_evt is the rising edge of start after a 3-flop synchronizer. It is a single-cycle pulse.
- IDLE: ball_rst=1, move_en=0. On start_evt, clear the scores and counter, then go to SERVE.
- SERVE: ball_rst=1, move_en=0. The counter increments on each fsync. When fsync arrives with counter == SERVE_FRAMES-1, go to PLAY and clear the counter.
- PLAY: ball_rst=0, move_en=1.
  - miss_top alone: score_bot+1, serve_dir=0, go to POINT.
  - miss_bot alone: score_top+1, serve_dir=1, go to POINT.
  - Both in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
- POINT: ball_rst=0, move_en=0, so the ball stays frozen at the miss location. The counter counts fsync. On fsync with counter == POINT_FRAMES-1:
  - If either score equals WIN_SCORE, go to OVER. winner=1 if score_bot==WIN_SCORE, else 0.
  - Otherwise go to SERVE.
  - The counter clears on either transition.
- OVER: game_over=1, move_en=0, ball_rst=1, scores held. On start_evt, clear the scores, set game_over=0, then go to SERVE.
- miss_* pulses outside PLAY are ignored. start_evt outside IDLE/OVER is ignored.
- Scores never exceed WIN_SCORE, because the game ends first. No wrap logic is required beyond that.
- Counter width is $clog2(max(SERVE_FRAMES,POINT_FRAMES)).

## Timing
- All outputs are registered and change one cycle after the causing event; there are no combinational paths from input to output.
- Latency from start pin to state change is 4 cycles: 3 sync flops plus the edge register.
- A miss pulse coincident with fsync in PLAY is scored. move_en drops the cycle after, so the gated fsync of that frame still reaches the objects.
- Frame counts are exact: PLAY is entered on the SERVE_FRAMES-th fsync after entering SERVE.
- A rst assertion mid-game returns to reset values on the next edge, regardless of state.

## Configuration
- AUTO_SERVE_EN defined: SERVE exits on the frame count as specified above.
- AUTO_SERVE_EN undefined: SERVE exits only on a start_evt received after the count completes; earlier start_evt is ignored. Auto-play still stops at OVER.

## Structure
- Package pong_pkg holds:
  - the state_t enum (3-bit, encodings as listed);
  - STATE_W;
  - serve direction constants DIR_TOP=0 and DIR_BOT=1.
- Sub-module sync_edge: a 3-flop synchronizer plus rising-edge detector for start. It is reusable for other paddle buttons.

## Test plan
- Reset, then start high for 10 cycles: state reaches SERVE 4 cycles after the edge. With AUTO_SERVE_EN defined, PLAY is entered on the 60th fsync; move_en=1 and ball_rst=0.
- In PLAY, pulse miss_top: score_bot=1, serve_dir=0, state=POINT. After 90 fsyncs, state=SERVE.
- In PLAY, pulse miss_top and miss_bot together: scores unchanged, serve_dir unchanged, state=POINT.
- Drive seven miss_bot rallies: score_top=7, OVER after the 7th POINT wait, game_over=1, winner=0. Then a start edge clears the scores and gives SERVE.
- Pulse miss_top in SERVE and in POINT: no score change. Pulse start in PLAY: no effect.
- Assert rst in POINT with score 3–2: the next cycle shows IDLE, scores 0, ball_rst=1, move_en=0.
